// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode values, ALUOp / PCSource / ALUSrcB select codes, the bundled
// control-output struct, and the opcode legality check.
//
// Build option: CTRL_ADDI_EN -- when defined, addi (001000) is a supported
// opcode; otherwise it is reported as illegal.
// -----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADDR  = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    RTYPE_WB = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    ADDI_EX  = 4'd11,
    ADDI_WB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  // True when DECODE has a defined successor for this opcode.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ)   || (op == OP_J);
`ifdef CTRL_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational Moore decoder: current state -> datapath control
// signals. mem_ready only gates IRWrite/PCWrite in FETCH so the IR and PC
// load exactly on the cycle the instruction word arrives.
//
// Ports:
//   state_i      current FSM state
//   mem_ready_i  memory handshake
//   ctrl_o       bundled control outputs (all zero for IDLE and unused codes)
//
// Build option: CTRL_ADDI_EN -- decodes ADDI_EX / ADDI_WB when defined.
// -----------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    // NOTE: defaulting every field before the case keeps this purely
    // combinational -- any path that skips an assignment would infer a latch.
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEMADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      RTYPE_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
`ifdef CTRL_ADDI_EN
      ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multicycle MIPS control FSM. Holds the state register and next-state
// logic; output decoding lives in ctrl_decode.
//
// Ports:
//   clock        system clock (posedge)
//   reset        synchronous, active-low reset (-> IDLE)
//   opcode       instruction[31:26] from the IR
//   mem_ready    memory done, sampled in FETCH / MEMREAD / MEMWRITE
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst
//                datapath controls
//   state        current state, for debug
//   illegal_op   one-cycle pulse in DECODE for an unsupported opcode
//
// Build option: CTRL_ADDI_EN -- enables the addi path (ADDI_EX, ADDI_WB).
// Without it, encodings 11/12 are treated like 13-15 and recover to FETCH.
// -----------------------------------------------------------------------------
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic [1:0]     PCSource,
  output logic [1:0]     ALUOp,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic           RegWrite,
  output logic           RegDst,
  output logic [STW-1:0] state,
  output logic           illegal_op
);

  state_t     state_q, state_d;
  logic [5:0] op;
  ctrl_t      ctrl;

  assign op = 6'(opcode);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_RTYPE:      state_d = EXECUTE;
          OP_LW, OP_SW:  state_d = MEMADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:       state_d = ADDI_EX;
`endif
          default:       state_d = FETCH;
        endcase
      end
      // IRWrite is low here, so the opcode still belongs to this lw/sw.
      MEMADDR:  state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
      EXECUTE:  state_d = RTYPE_WB;
      RTYPE_WB: state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
`ifdef CTRL_ADDI_EN
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // NOTE: state uses non-blocking assignment so every flop samples the
  // pre-edge value; reset is checked inside the clocked block, making it
  // synchronous and able to abort a stalled memory state on any edge.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;

  assign state      = STW'(state_q);
  assign illegal_op = (state_q == DECODE) && !op_supported(op);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle MIPS control FSM; sits directly upstream of the datapath muxes and the branch AND gate.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives RegDst (5-bit register-destination mux), MemtoReg/ALUSrc selects (32-bit muxes), and PCWriteCond (branch AND input).
- Waits on a memory-ready handshake in every memory state.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, state register width.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset.
- opcode  input  OPW  instruction[31:26] from the instruction register.
- mem_ready  input  1  memory done; sampled in FETCH, MEMREAD, MEMWRITE.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  branch-conditional PC load; feeds AND with ALU zero.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  write-data mux select: 0=ALUOut, 1=MDR.
- PCSource  output  2  PC mux select: 00=ALU, 01=ALUOut, 10=jump target.
- ALUOp  output  2  00=add, 01=sub, 10=funct-decoded.
- ALUSrcA  output  1  ALU A select: 0=PC, 1=rs.
- ALUSrcB  output  2  ALU B select: 00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  destination register select: 0=rt, 1=rd.
- state  output  STW  current state, for debug.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset: if reset==0 at a posedge, state <= IDLE. In IDLE every output is 0, including state=0 and illegal_op=0. IDLE -> FETCH unconditionally next cycle. Reset applies from any state, including a stalled memory state; no partial write completes after that edge.
- Outputs are Moore, decoded combinationally from state. Only exception: the mem_ready gating listed below. Any signal not listed for a state is 0.
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, RTYPE_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12.
  - Encodings 13-15 are illegal and go to FETCH.
- FETCH:
  - Outputs: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcB=11, ALUOp=00.
  - Next state by opcode: 000000 -> EXECUTE; 100011 (lw) or 101011 (sw) -> MEMADDR; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi) -> ADDI_EX.
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> MEMREAD if lw, MEMWRITE if sw. Opcode is held stable by the IR, since IRWrite=0.
- MEMREAD: MemRead=1, IorD=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Holds until mem_ready=1, then -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
- JUMP: PCWrite=1, PCSource=10. -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
- Latency with mem_ready tied to 1 (cycles from FETCH back to FETCH):
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each cycle of mem_ready=0 in a memory state adds one cycle.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in the same cycle as PCWrite.

Optional Feature:
- Macro: CTRL_ADDI_EN.
- Defined: addi (001000) is decoded as above.
- Undefined: ADDI_EX and ADDI_WB are not synthesised; opcode 001000 is treated as illegal (illegal_op pulse, -> FETCH). Encodings 11 and 12 become illegal states.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding constants (IDLE..ADDI_WB);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - PCSource constants PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP.
- One sub-module, ctrl_decode: purely combinational state+mem_ready -> control-output decoder. The top level keeps the state register and next-state logic.

Test Plan:
- reset=0 for 2 cycles, then 1 -> all outputs 0 and state=0 during reset; state=1 the cycle after release; MemRead=1 in FETCH.
- opcode=000000, mem_ready=1 -> states 1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8.
- opcode=100011, mem_ready low for 3 cycles in MEMREAD -> state stays 4 for 4 cycles with IorD=1; then MEMWB with RegWrite=1, MemtoReg=1.
- opcode=000100, then 000010 -> BRANCH gives PCWriteCond=1, ALUOp=01, PCSource=01; JUMP gives PCWrite=1, PCSource=10; each returns to FETCH after 3 cycles.
- opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state 1. opcode=001000 -> ADDI path with CTRL_ADDI_EN defined; illegal_op pulse without it.
- reset driven 0 while stalled in MEMWRITE -> next state IDLE, MemWrite=0, no further write strobe.
